fetch_sequencer: RTL

Program-counter sequencer for the 9-bit-instruction core. It owns the 16-bit PC that addresses the combinational instruction ROM and runs a start/done handshake with the test harness. It applies absolute and relative branch redirects from the decoder, honours a stall from the datapath, and detects the halt opcode. It sits between the top-level harness, the instruction ROM and the decode/branch logic, and also counts executed cycles for reporting.

---
 rtl/fetch_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: owns the PC, runs the start/done handshake,
// applies stalls and absolute/relative branches, and counts RUN cycles.
module fetch_sequencer #(
    parameter int unsigned       PW       = 16,
    parameter int unsigned       IW       = 9,
    parameter logic [PW-1:0]     START_PC = '0,
    parameter logic [IW-1:0]     HALT_OP  = '1
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [IW-1:0] Inst,
    input  logic          Stall,
    input  logic          BranchAbs,
    input  logic          BranchRel,
    input  logic [PW-1:0] Target,
    output logic [PW-1:0] PC,
    output logic          InstValid,
    output logic          Done,
    output logic [15:0]   CycleCount
);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [15:0]   cycle_count_q, cycle_count_d;
    logic [15:0]   cycle_count_inc;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q       <= StIdle;
            pc_q          <= START_PC;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // Saturating count: every RUN cycle counts, stalled or halting included.
    assign cycle_count_inc = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cycle_count_d = cycle_count_q;
        case (state_q)
            StIdle, StHalted: begin
                if (Start) begin
                    state_d       = StRun;
                    pc_d          = START_PC;
                    cycle_count_d = '0;
                end
            end
            StRun: begin
                cycle_count_d = cycle_count_inc;
                if (Stall) begin
                    pc_d = pc_q;
                end else if (Inst == HALT_OP) begin
                    state_d = StHalted;
                end else if (BranchAbs) begin
                    pc_d = Target;
                end else if (BranchRel) begin
                    // Two's-complement add gives signed offset semantics modulo 2^PW.
                    pc_d = pc_q + Target;
                end else begin
                    pc_d = pc_q + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign PC         = pc_q;
    assign InstValid  = (state_q == StRun);
    assign Done       = (state_q == StHalted);
    assign CycleCount = cycle_count_q;

endmodule
